// File: rtl/digit_scan_ctrl.sv
`timescale 1ns/1ps
// digit_scan_ctrl
//   Time-multiplexed digit scanner driving a 3-to-8 decoder (74x138 style).
//   Each digit is enabled for DIV clocks. An optional blank gap of BLANK_CYC
//   clocks separates digits so that ghosting does not appear while the select
//   lines change.
//
//   Build option: define SCAN_BLANK_EN to include the BLANK state and its
//   counter. Without it, digits follow back-to-back and BLANK_CYC is ignored.
//
// Ports
//   clk      in   single clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   en       in   scan enable (level); 0 forces idle with idx 0
//   E1       out  decoder enable, active-high
//   E2, E3   out  decoder enables, active-low (always ~E1)
//   A, B, C  out  decoder select bits idx[0], idx[1], idx[2]
//   DIG_IDX  out  current digit index {C,B,A}
//   DIG_STB  out  one-cycle pulse on the first enabled cycle of a digit
module digit_scan_ctrl #(
    parameter int unsigned DIV        = 50000,
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned BLANK_CYC  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic       E1,
    output logic       E2,
    output logic       E3,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic [2:0] DIG_IDX,
    output logic       DIG_STB
);

`ifdef SCAN_BLANK_EN
    typedef enum logic [1:0] {StIdle, StActive, StBlank} state_t;
`else
    typedef enum logic [1:0] {StIdle, StActive} state_t;
`endif

    localparam logic [15:0] PreTc   = 16'(DIV - 1);
    localparam logic [2:0]  LastIdx = 3'(NUM_DIGITS - 1);

    state_t      state_q;
    logic [15:0] presc_q;
    logic [2:0]  idx_q;
    logic        e1_q;
    logic        stb_q;
    logic [2:0]  idx_next;

`ifdef SCAN_BLANK_EN
    localparam logic [7:0] BlankTc = 8'(BLANK_CYC - 1);
    logic [7:0] blank_q;
`else
    // BLANK_CYC has no effect in this build.
    logic unused_blank_cyc;
    assign unused_blank_cyc = ^8'(BLANK_CYC);
`endif

    assign idx_next = (idx_q == LastIdx) ? 3'd0 : idx_q + 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            presc_q <= '0;
            idx_q   <= '0;
            e1_q    <= 1'b0;
            stb_q   <= 1'b0;
`ifdef SCAN_BLANK_EN
            blank_q <= '0;
`endif
        end else if (!en) begin
            // Dropping en wins over every other transition, including
            // terminal count; the dwell is abandoned and restarts at idx 0.
            state_q <= StIdle;
            presc_q <= '0;
            idx_q   <= '0;
            e1_q    <= 1'b0;
            stb_q   <= 1'b0;
`ifdef SCAN_BLANK_EN
            blank_q <= '0;
`endif
        end else begin
            stb_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    state_q <= StActive;
                    presc_q <= '0;
                    idx_q   <= '0;
                    e1_q    <= 1'b1;
                    stb_q   <= 1'b1;
                end
                StActive: begin
                    if (presc_q == PreTc) begin
                        // Select lines move on the edge that ends the dwell,
                        // so they are already settled during the blank gap.
                        idx_q   <= idx_next;
                        presc_q <= '0;
`ifdef SCAN_BLANK_EN
                        state_q <= StBlank;
                        blank_q <= '0;
                        e1_q    <= 1'b0;
`else
                        stb_q   <= 1'b1;
`endif
                    end else begin
                        presc_q <= presc_q + 16'd1;
                    end
                end
`ifdef SCAN_BLANK_EN
                StBlank: begin
                    if (blank_q == BlankTc) begin
                        state_q <= StActive;
                        presc_q <= '0;
                        e1_q    <= 1'b1;
                        stb_q   <= 1'b1;
                    end else begin
                        blank_q <= blank_q + 8'd1;
                    end
                end
`endif
                default: begin
                    state_q <= StIdle;
                    idx_q   <= '0;
                    e1_q    <= 1'b0;
                end
            endcase
        end
    end

    assign E1      = e1_q;
    assign E2      = ~e1_q;
    assign E3      = ~e1_q;
    assign A       = idx_q[0];
    assign B       = idx_q[1];
    assign C       = idx_q[2];
    assign DIG_IDX = idx_q;
    assign DIG_STB = stb_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for digit_scan_ctrl: stimulus pushes expected strobe
// events (cycle, index); a negedge monitor pops and compares on every DIG_STB.
// A second instance with NUM_DIGITS=5 runs on the same stimulus.
module tb_digit_scan_ctrl;

    localparam int DIV = 4;
    localparam int BLK = 2;
`ifdef SCAN_BLANK_EN
    localparam int P        = DIV + BLK;
    localparam int HasBlank = 1;
`else
    localparam int P        = DIV;
    localparam int HasBlank = 0;
`endif

    typedef struct {
        int cyc;
        int idx;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       E1, E2, E3, A, B, C, DIG_STB;
    logic [2:0] DIG_IDX;
    logic       E1_5, E2_5, E3_5, A_5, B_5, C_5, DIG_STB_5;
    logic [2:0] DIG_IDX_5;

    int   cyc;
    int   checks;
    int   errors;
    exp_t q8[$];
    exp_t q5[$];

    digit_scan_ctrl #(.DIV(DIV), .NUM_DIGITS(8), .BLANK_CYC(BLK)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .E1(E1), .E2(E2), .E3(E3), .A(A), .B(B), .C(C),
        .DIG_IDX(DIG_IDX), .DIG_STB(DIG_STB)
    );

    digit_scan_ctrl #(.DIV(DIV), .NUM_DIGITS(5), .BLANK_CYC(BLK)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .en(en),
        .E1(E1_5), .E2(E2_5), .E3(E3_5), .A(A_5), .B(B_5), .C(C_5),
        .DIG_IDX(DIG_IDX_5), .DIG_STB(DIG_STB_5)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at cyc %0d: got %0d expected %0d", name, cyc, act, req);
        end
    endtask

    // Strobe k of a scan that started with a strobe at cycle c0.
    task automatic push(input int c0, input int k);
        q8.push_back('{c0 + k * P, k % 8});
        q5.push_back('{c0 + k * P, k % 5});
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Monitor: every strobe must match the head of its queue.
    always @(negedge clk) begin
        exp_t e;
        if (DIG_STB) begin
            if (q8.size() == 0) begin
                check("stb8_unexpected", 1, 0);
            end else begin
                e = q8.pop_front();
                check("stb8_cyc", cyc, e.cyc);
                check("stb8_idx", int'(DIG_IDX), e.idx);
                check("stb8_cba", int'({C, B, A}), e.idx);
                check("stb8_e1", int'(E1), 1);
            end
        end
        if (DIG_STB_5) begin
            if (q5.size() == 0) begin
                check("stb5_unexpected", 1, 0);
            end else begin
                e = q5.pop_front();
                check("stb5_cyc", cyc, e.cyc);
                check("stb5_idx", int'(DIG_IDX_5), e.idx);
            end
        end
    end

    initial begin
        int s;
        int s2;
        int s3;
        int x;
        int r;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        en     = 1'b0;

        // Reset values.
        @(negedge clk);
        wait_until(3);
        check("rst_e1", int'(E1), 0);
        check("rst_e2", int'(E2), 1);
        check("rst_e3", int'(E3), 1);
        check("rst_idx", int'(DIG_IDX), 0);
        check("rst_stb", int'(DIG_STB), 0);
        rst_n = 1'b1;
        wait_until(5);
        check("idle_e1", int'(E1), 0);

        // Full scan: 0..7,0 with wrap; period P per digit.
        s  = cyc;
        en = 1'b1;
        for (int k = 0; k <= 8; k++) push(s + 1, k);
        wait_until(s + 1);
        check("act_e2", int'(E2), 0);
        check("act_e3", int'(E3), 0);
        wait_until(s + 4);
        check("act_last_e1", int'(E1), 1);
        wait_until(s + 5);
        check("after_dwell_e1", int'(E1), HasBlank ? 0 : 1);
        check("after_dwell_e2", int'(E2), HasBlank ? 1 : 0);
        check("after_dwell_idx", int'(DIG_IDX), 1);
        check("after_dwell_a", int'(A), 1);
        wait_until(s + 2 + 8 * P);
        en = 1'b0;
        wait_until(s + 3 + 8 * P);
        check("stop_e1", int'(E1), 0);

        // en dropped in the 2nd cycle of idx 3, then restart at idx 0.
        wait_until(s + 5 + 8 * P);
        s2 = cyc;
        en = 1'b1;
        for (int k = 0; k <= 3; k++) push(s2 + 1, k);
        wait_until(s2 + 2 + 3 * P);
        check("pre_drop_idx", int'(DIG_IDX), 3);
        en = 1'b0;
        wait_until(s2 + 3 + 3 * P);
        check("drop_e1", int'(E1), 0);
        check("drop_e2", int'(E2), 1);
        check("drop_idx", int'(DIG_IDX), 0);
        check("drop_idx5", int'(DIG_IDX_5), 0);
        s3 = cyc + 1;
        wait_until(s3);
        en = 1'b1;
        push(s3 + 1, 0);
        push(s3 + 1, 1);

        // Asynchronous reset mid-BLANK (mid-dwell without blanking).
        x = s3 + 5 + P;
        if (HasBlank == 0) push(s3 + 1, 2);
        wait_until(x);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_e1", int'(E1), 0);
        check("arst_e2", int'(E2), 1);
        check("arst_e3", int'(E3), 1);
        check("arst_idx", int'(DIG_IDX), 0);
        check("arst_cba", int'({C, B, A}), 0);
        check("arst_stb", int'(DIG_STB), 0);
        check("arst_idx5", int'(DIG_IDX_5), 0);
        @(negedge clk);
        wait_until(cyc + 2);
        r     = cyc;
        rst_n = 1'b1;
        push(r + 1, 0);
        push(r + 1, 1);
        wait_until(r + 2 + P);

        check("q8_drained", q8.size(), 0);
        check("q5_drained", q5.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop in case the stimulus stalls.
    initial begin
        #100000;
        $display("FAIL timeout at cyc %0d: got running expected finished", cyc);
        $fatal(1);
    end

endmodule
